// File: rtl/writeback_arbiter_if.sv
// rtl/writeback_arbiter_if.sv - writeback producer/consumer bundle for the writeback arbiter
//
// Groups the requester side (req_*, flush, req_ready) and the registered
// writeback broadcast (wb_*) so the arbiter and its neighbours share one bundle.
//   slave  : the arbiter's view (consumes req_*/flush, drives req_ready/wb_*)
//   master : the surrounding core's view (drives req_*/flush, observes outputs)
// Per-requester payloads are packed, requester i at slice [i*W +: W].

interface writeback_arbiter_if #(
  parameter int NUM_REQ         = 3,
  parameter int PHYS_REG_WIDTH  = 6,
  parameter int ROB_INDEX_WIDTH = 5
);
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_reg_write;
  logic [NUM_REQ*PHYS_REG_WIDTH-1:0]  req_phys_reg_tag;
  logic [NUM_REQ*32-1:0]              req_data;
  logic [NUM_REQ*ROB_INDEX_WIDTH-1:0] req_ROB_index;
  logic                               flush;
  logic [NUM_REQ-1:0]                 req_ready;

  logic                               wb_valid;
  logic                               wb_reg_write;
  logic [PHYS_REG_WIDTH-1:0]          wb_phys_reg_tag;
  logic [31:0]                        wb_data;
  logic [ROB_INDEX_WIDTH-1:0]         wb_ROB_index;
  logic [NUM_REQ-1:0]                 wb_source;

  modport slave (
    input  req_valid, req_reg_write, req_phys_reg_tag, req_data, req_ROB_index, flush,
    output req_ready,
    output wb_valid, wb_reg_write, wb_phys_reg_tag, wb_data, wb_ROB_index, wb_source
  );

  modport master (
    output req_valid, req_reg_write, req_phys_reg_tag, req_data, req_ROB_index, flush,
    input  req_ready,
    input  wb_valid, wb_reg_write, wb_phys_reg_tag, wb_data, wb_ROB_index, wb_source
  );
endinterface

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - round-robin arbiter onto the single register-file writeback port
//
// Grants at most one valid requester per cycle (round-robin, starting after
// the last granted one), registers its result into one writeback stage and
// broadcasts it to the phys reg file, ready table and ROB.
// Ports:
//   CLK   - clock, rising edge
//   nRST  - asynchronous active-low reset
//   bus   - writeback_arbiter_if.slave: req_* / flush in, req_ready
//           (combinational one-hot-or-zero grant) and registered wb_* out

module writeback_arbiter #(
  parameter int NUM_REQ         = 3,
  parameter int PHYS_REG_WIDTH  = 6,
  parameter int ROB_INDEX_WIDTH = 5
) (
  input  logic                  CLK,
  input  logic                  nRST,
  writeback_arbiter_if.slave    bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]           rr_last;
  logic [IDX_W-1:0]           grant_idx;
  logic                       grant_found;
  logic [NUM_REQ-1:0]         grant_onehot;
  int                         cand;

  logic                       sel_reg_write;
  logic [PHYS_REG_WIDTH-1:0]  sel_tag;
  logic [31:0]                sel_data;
  logic [ROB_INDEX_WIDTH-1:0] sel_rob;

  // Walk rr_last+1 .. rr_last+NUM_REQ (mod NUM_REQ); the last step lands on
  // rr_last itself so a lone requester can be granted back-to-back.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(rr_last) + k) % NUM_REQ;
      if (!grant_found && !bus.flush && bus.req_valid[IDX_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  assign grant_onehot  = grant_found ? (NUM_REQ'(1) << grant_idx) : '0;
  assign bus.req_ready = grant_onehot;

  always_comb begin
    sel_reg_write = 1'b0;
    sel_tag       = '0;
    sel_data      = '0;
    sel_rob       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_onehot[i]) begin
        sel_reg_write = bus.req_reg_write[i];
        sel_tag       = bus.req_phys_reg_tag[i*PHYS_REG_WIDTH +: PHYS_REG_WIDTH];
        sel_data      = bus.req_data[i*32 +: 32];
        sel_rob       = bus.req_ROB_index[i*ROB_INDEX_WIDTH +: ROB_INDEX_WIDTH];
      end
    end
  end

  // A grant is always a transfer (ready only ever asserts alongside valid).
  // Idle cycles clear the qualifiers but keep the payload fields as they were.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_last             <= IDX_W'(NUM_REQ - 1);
      bus.wb_valid        <= 1'b0;
      bus.wb_reg_write    <= 1'b0;
      bus.wb_phys_reg_tag <= '0;
      bus.wb_data         <= '0;
      bus.wb_ROB_index    <= '0;
      bus.wb_source       <= '0;
    end else if (grant_found) begin
      rr_last             <= grant_idx;
      bus.wb_valid        <= 1'b1;
      bus.wb_reg_write    <= sel_reg_write;
      bus.wb_phys_reg_tag <= sel_tag;
      bus.wb_data         <= sel_data;
      bus.wb_ROB_index    <= sel_rob;
      bus.wb_source       <= grant_onehot;
    end else begin
      bus.wb_valid        <= 1'b0;
      bus.wb_reg_write    <= 1'b0;
      bus.wb_source       <= '0;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - directed and randomized bench for writeback_arbiter

module tb_writeback_arbiter;

  localparam int N  = 3;
  localparam int TW = 6;
  localparam int RW = 5;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  writeback_arbiter_if #(.NUM_REQ(N), .PHYS_REG_WIDTH(TW), .ROB_INDEX_WIDTH(RW)) bus ();

  writeback_arbiter #(.NUM_REQ(N), .PHYS_REG_WIDTH(TW), .ROB_INDEX_WIDTH(RW)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  // requester-side payloads
  logic [N-1:0]  p_valid;
  logic [N-1:0]  p_rw;
  logic [TW-1:0] p_tag  [N];
  logic [31:0]   p_data [N];
  logic [RW-1:0] p_rob  [N];
  logic          flush_v;

  // reference model of the writeback stage
  int            rr;
  logic          m_valid, m_rw;
  logic [TW-1:0] m_tag;
  logic [31:0]   m_data;
  logic [RW-1:0] m_rob;
  logic [N-1:0]  m_src;
  int            wait_cnt [N];
  int            last_g;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    rr = N - 1;
    m_valid = 0; m_rw = 0; m_tag = '0; m_data = '0; m_rob = '0; m_src = '0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
  endtask

  // Winner = valid requester with the smallest forward distance from the
  // requester after rr (distance 0 .. N-1).
  function automatic int model_grant();
    int best, bestd, d;
    best = -1;
    bestd = N;
    if (flush_v) return -1;
    for (int i = 0; i < N; i++) begin
      d = (i - rr - 1 + 2 * N) % N;
      if (p_valid[i] && d < bestd) begin
        best = i;
        bestd = d;
      end
    end
    return best;
  endfunction

  task automatic drive();
    bus.flush = flush_v;
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]                  = p_valid[i];
      bus.req_reg_write[i]              = p_rw[i];
      bus.req_phys_reg_tag[i*TW +: TW]  = p_tag[i];
      bus.req_data[i*32 +: 32]          = p_data[i];
      bus.req_ROB_index[i*RW +: RW]     = p_rob[i];
    end
  endtask

  task automatic setp(input int i, input logic rw, input logic [TW-1:0] tag,
                      input logic [31:0] data, input logic [RW-1:0] rob);
    p_valid[i] = 1'b1;
    p_rw[i]    = rw;
    p_tag[i]   = tag;
    p_data[i]  = data;
    p_rob[i]   = rob;
  endtask

  task automatic check_wb(input string tag);
    chk({tag, ".wb_valid"},  64'(bus.wb_valid),        64'(m_valid));
    chk({tag, ".wb_rw"},     64'(bus.wb_reg_write),    64'(m_rw));
    chk({tag, ".wb_tag"},    64'(bus.wb_phys_reg_tag), 64'(m_tag));
    chk({tag, ".wb_data"},   64'(bus.wb_data),         64'(m_data));
    chk({tag, ".wb_rob"},    64'(bus.wb_ROB_index),    64'(m_rob));
    chk({tag, ".wb_source"}, 64'(bus.wb_source),       64'(m_src));
  endtask

  // One clock: entered just after a falling edge, leaves at the next one.
  task automatic cycle(input string tag);
    int g;
    logic [N-1:0] exp_rdy;
    drive();
    #1;
    g = model_grant();
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    chk({tag, ".req_ready"}, 64'(bus.req_ready), 64'(exp_rdy));
    check_wb({tag, ".pre"});
    @(posedge CLK);
    #1;
    if (!flush_v)
      for (int i = 0; i < N; i++)
        if (p_valid[i] && i != g) wait_cnt[i]++;
    if (g >= 0) begin
      m_valid = 1'b1;
      m_rw    = p_rw[g];
      m_tag   = p_tag[g];
      m_data  = p_data[g];
      m_rob   = p_rob[g];
      m_src   = N'(1) << g;
      rr      = g;
      chk({tag, ".fair"}, 64'(wait_cnt[g] < N), 64'd1);
      wait_cnt[g] = 0;
      p_valid[g]  = 1'b0;
    end else begin
      m_valid = 1'b0;
      m_rw    = 1'b0;
      m_src   = '0;
    end
    last_g = g;
    check_wb(tag);
    @(negedge CLK);
  endtask

  // Asynchronous reset pulse inside the low clock phase.
  task automatic do_reset(input string tag);
    #2;
    nRST = 1'b0;
    p_valid = '0;
    flush_v = 1'b0;
    drive();
    #1;
    model_reset();
    check_wb(tag);
    chk({tag, ".req_ready"}, 64'(bus.req_ready), 64'd0);
    #1;
    nRST = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    nRST    = 1'b0;
    p_valid = '0;
    p_rw    = '0;
    flush_v = 1'b0;
    for (int i = 0; i < N; i++) begin
      p_tag[i] = '0; p_data[i] = '0; p_rob[i] = '0;
    end
    last_g = -1;
    model_reset();
    drive();
    @(negedge CLK);
    do_reset("rst");

    // single request
    setp(1, 1'b1, 6'd40, 32'hDEADBEEF, 5'd7);
    cycle("single");
    chk("single.data_const", 64'(bus.wb_data), 64'hDEADBEEF);
    chk("single.src_const", 64'(bus.wb_source), 64'b010);

    // full contention from reset
    do_reset("rst2");
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++)
        if (!p_valid[i]) setp(i, 1'b1, TW'($urandom), $urandom, RW'($urandom));
      cycle("cont");
      chk("cont.order", 64'(last_g), 64'(c % 3));
    end
    p_valid = '0;

    // wrap-around with requesters 0 and 2 (rr_last = 2)
    for (int c = 0; c < 3; c++) begin
      if (!p_valid[0]) setp(0, 1'b1, TW'($urandom), $urandom, RW'($urandom));
      if (!p_valid[2]) setp(2, 1'b1, TW'($urandom), $urandom, RW'($urandom));
      cycle("wrap");
      chk("wrap.order", 64'(last_g), (c == 1) ? 64'd2 : 64'd0);
    end
    p_valid = '0;

    // flush for two cycles, rotation resumes after rr_last (= 0)
    for (int i = 0; i < N; i++) setp(i, 1'b1, TW'($urandom), $urandom, RW'($urandom));
    flush_v = 1'b1;
    cycle("flush1");
    cycle("flush2");
    flush_v = 1'b0;
    cycle("after_flush");
    chk("after_flush.order", 64'(last_g), 64'd1);
    p_valid = '0;

    // ROB-only completion
    setp(2, 1'b0, 6'd12, 32'h1234_5678, 5'd19);
    cycle("rob_only");
    chk("rob_only.rw_const", 64'(bus.wb_reg_write), 64'd0);
    chk("rob_only.rob_const", 64'(bus.wb_ROB_index), 64'd19);

    // reset while the writeback stage is valid
    setp(0, 1'b1, 6'd5, 32'hCAFE_F00D, 5'd3);
    cycle("pre_mid");
    chk("mid.pre_wb_valid", 64'(bus.wb_valid), 64'd1);
    do_reset("mid");
    setp(1, 1'b1, TW'($urandom), $urandom, RW'($urandom));
    setp(2, 1'b1, TW'($urandom), $urandom, RW'($urandom));
    cycle("post_mid");
    chk("post_mid.order", 64'(last_g), 64'd1);
    p_valid = '0;

    // randomized traffic honouring the hold-until-ready contract
    for (int c = 0; c < 400; c++) begin
      flush_v = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < N; i++)
        if (!p_valid[i] && $urandom_range(0, 2) != 0)
          setp(i, 1'($urandom_range(0, 1)), TW'($urandom), $urandom, RW'($urandom));
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
